// File: rtl/ibex_trace_pkg.sv
// Shared types for the RVFI trace buffer: record layout, FSM states, record width.
// Optional timestamp field controlled by IBEX_TRACE_TIMESTAMP_EN.
package ibex_trace_pkg;

  localparam int unsigned TRACE_ORDER_W = 16;

`ifdef IBEX_TRACE_TIMESTAMP_EN
  localparam int unsigned TS_W = 32;
`else
  localparam int unsigned TS_W = 0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_FROZEN  = 2'd3
  } trace_state_e;

  // Record layout at the default order width, MSB first.
  typedef struct packed {
    logic [TRACE_ORDER_W-1:0] order;
    logic [31:0]              pc;
    logic [31:0]              insn;
    logic [4:0]               rd_addr;
    logic [31:0]              rd_wdata;
    logic                     trap;
    logic                     intr;
`ifdef IBEX_TRACE_TIMESTAMP_EN
    logic [31:0]              ts;
`endif
  } trace_rec_t;

  // Record width for a given kept-order width.
  function automatic int unsigned rec_w(input int unsigned order_w);
    return order_w + 32'd103 + TS_W;
  endfunction

endpackage

// File: rtl/ibex_trace_fifo.sv
// Multi-write (up to NRET per cycle), single-read first-word-fall-through FIFO.
// DEPTH must be a power of two >= 2; pointers wrap naturally.
module ibex_trace_fifo #(
  parameter int unsigned NRET  = 1,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned W     = 119,
  localparam int unsigned CW    = $clog2(NRET + 1),
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned LVL_W = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic [CW-1:0]    wr_cnt_i,
  input  logic [W-1:0]     wr_data_i [NRET],
  input  logic             pop_i,
  output logic [W-1:0]     rd_data_o,
  output logic [LVL_W-1:0] level_o
);

  logic [W-1:0]     r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LVL_W-1:0] r_level;
  logic             w_pop;

  assign w_pop     = pop_i && (r_level != '0);
  assign level_o   = r_level;
  assign rd_data_o = (r_level != '0) ? r_mem[r_rd_ptr] : '0;

  // Storage: compacted slots land at consecutive write positions.
  always_ff @(posedge clk_i) begin
    for (int s = 0; s < NRET; s++) begin
      if (!clr_i && (CW'(s) < wr_cnt_i)) begin
        r_mem[r_wr_ptr + AW'(s)] <= wr_data_i[s];
      end
    end
  end

  // Pointers and occupancy; clear overrides same-cycle push and pop.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (clr_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      r_wr_ptr <= r_wr_ptr + AW'(wr_cnt_i);
      r_rd_ptr <= r_rd_ptr + AW'(w_pop);
      r_level  <= r_level + LVL_W'(wr_cnt_i) - LVL_W'(w_pop);
    end
  end

endmodule

// File: rtl/ibex_trace_buffer.sv
// RVFI trace capture: packs retirements into records, buffers and streams them.
// Define IBEX_TRACE_TIMESTAMP_EN to append a 32-bit cycle timestamp to each record.
module ibex_trace_buffer
  import ibex_trace_pkg::*;
#(
  parameter int unsigned NRET    = 1,
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned ORDER_W = 16,
  parameter int unsigned CNT_W   = 16,
  localparam int unsigned REC_W  = rec_w(ORDER_W),
  localparam int unsigned LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               cfg_enable_i,
  input  logic [1:0]         cfg_mode_i,
  input  logic [31:0]        cfg_trig_pc_i,
  input  logic               cfg_clear_i,
  input  logic [NRET-1:0]    rvfi_valid,
  input  logic [NRET*64-1:0] rvfi_order,
  input  logic [NRET*32-1:0] rvfi_insn,
  input  logic [NRET*32-1:0] rvfi_pc_rdata,
  input  logic [NRET*5-1:0]  rvfi_rd_addr,
  input  logic [NRET*32-1:0] rvfi_rd_wdata,
  input  logic [NRET-1:0]    rvfi_trap,
  input  logic [NRET-1:0]    rvfi_intr,
  output logic               trace_valid_o,
  input  logic               trace_ready_i,
  output logic [REC_W-1:0]   trace_data_o,
  output logic [LVL_W-1:0]   level_o,
  output logic [CNT_W-1:0]   drop_cnt_o,
  output logic [1:0]         state_o
);

  localparam int unsigned CW  = $clog2(NRET + 1);
  localparam int unsigned DSW = CNT_W + 1;

  trace_state_e     r_state;
  trace_state_e     w_state_nxt;
  logic [NRET-1:0]  w_cand;
  logic             w_trig_hit;
  logic [CW-1:0]    w_ncand;
  logic [CW-1:0]    w_wr_cnt;
  logic             w_drop;
  logic [REC_W-1:0] w_lane_rec [NRET];
  logic [REC_W-1:0] w_slot_rec [NRET];
  logic [LVL_W-1:0] w_level;
  logic [CNT_W-1:0] r_drop;
  logic [DSW-1:0]   w_drop_sum;
  logic             w_pop;
  logic             w_unused_order;
`ifdef IBEX_TRACE_TIMESTAMP_EN
  logic [31:0]      r_ts;
`endif

  // Only the low ORDER_W bits of each lane's order are recorded.
  assign w_unused_order = ^rvfi_order;

  // Per-lane record assembly in the fixed field order.
  for (genvar l = 0; l < NRET; l++) begin : g_lane
`ifdef IBEX_TRACE_TIMESTAMP_EN
    assign w_lane_rec[l] = {rvfi_order[l*64 +: ORDER_W], rvfi_pc_rdata[l*32 +: 32],
                            rvfi_insn[l*32 +: 32], rvfi_rd_addr[l*5 +: 5],
                            rvfi_rd_wdata[l*32 +: 32], rvfi_trap[l], rvfi_intr[l], r_ts};
`else
    assign w_lane_rec[l] = {rvfi_order[l*64 +: ORDER_W], rvfi_pc_rdata[l*32 +: 32],
                            rvfi_insn[l*32 +: 32], rvfi_rd_addr[l*5 +: 5],
                            rvfi_rd_wdata[l*32 +: 32], rvfi_trap[l], rvfi_intr[l]};
`endif
  end

  // Candidate lanes: all valid lanes in CAPTURE; trigger lane and younger in ARMED.
  always_comb begin
    logic seen;
    w_cand     = '0;
    w_ncand    = '0;
    w_trig_hit = 1'b0;
    seen       = 1'b0;
    for (int l = 0; l < NRET; l++) begin
      if (rvfi_valid[l] && (rvfi_pc_rdata[l*32 +: 32] == cfg_trig_pc_i)) begin
        seen = 1'b1;
      end
      if (cfg_enable_i && !cfg_clear_i) begin
        if (r_state == ST_CAPTURE) begin
          w_cand[l] = rvfi_valid[l];
        end else if (r_state == ST_ARMED) begin
          w_cand[l] = rvfi_valid[l] & seen;
        end
      end
      w_ncand = w_ncand + CW'(w_cand[l]);
    end
    w_trig_hit = seen;
  end

  // Space check against start-of-cycle occupancy; all-or-nothing write.
  assign w_drop   = (w_ncand != '0) && (int'(w_ncand) > int'(DEPTH) - int'(w_level));
  assign w_wr_cnt = w_drop ? '0 : w_ncand;

  // Lane compaction: the k-th candidate goes to write slot k.
  always_comb begin
    int k;
    for (int s = 0; s < NRET; s++) begin
      w_slot_rec[s] = '0;
    end
    k = 0;
    for (int l = 0; l < NRET; l++) begin
      for (int s = 0; s < NRET; s++) begin
        if (w_cand[l] && (k == s)) begin
          w_slot_rec[s] = w_lane_rec[l];
        end
      end
      if (w_cand[l]) begin
        k = k + 1;
      end
    end
  end

  // Next-state logic; disable and clear both return to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (cfg_clear_i || !cfg_enable_i) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cfg_mode_i == 2'd1) begin
            w_state_nxt = ST_ARMED;
          end else if ((cfg_mode_i == 2'd0) || (cfg_mode_i == 2'd2)) begin
            w_state_nxt = ST_CAPTURE;
          end
        end
        ST_ARMED: begin
          if (w_trig_hit) begin
            w_state_nxt = ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_drop && (cfg_mode_i == 2'd2)) begin
            w_state_nxt = ST_FROZEN;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + DSW'(w_ncand);

  // Saturating count of records refused for lack of space.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_drop <= '0;
    end else if (cfg_clear_i) begin
      r_drop <= '0;
    end else if (w_drop) begin
      r_drop <= w_drop_sum[CNT_W] ? '1 : w_drop_sum[CNT_W-1:0];
    end
  end

`ifdef IBEX_TRACE_TIMESTAMP_EN
  // Free-running cycle counter shared by all lanes of a cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 32'd1;
    end
  end
`endif

  assign w_pop = trace_valid_o & trace_ready_i;

  ibex_trace_fifo #(
    .NRET  (NRET),
    .DEPTH (DEPTH),
    .W     (REC_W)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .clr_i     (cfg_clear_i),
    .wr_cnt_i  (w_wr_cnt),
    .wr_data_i (w_slot_rec),
    .pop_i     (w_pop),
    .rd_data_o (trace_data_o),
    .level_o   (w_level)
  );

  assign trace_valid_o = (w_level != '0);
  assign level_o       = w_level;
  assign drop_cnt_o    = r_drop;
  assign state_o       = r_state;

endmodule

// File: tb/tb_ibex_trace_buffer.sv
`timescale 1ns/1ps
module tb_ibex_trace_buffer;
  import ibex_trace_pkg::*;

  localparam int unsigned NRET    = 2;
  localparam int unsigned DEPTH   = 16;
  localparam int unsigned ORDER_W = 16;
  localparam int unsigned CNT_W   = 16;
  localparam int unsigned REC_W   = rec_w(ORDER_W);
  localparam int unsigned LVL_W   = $clog2(DEPTH) + 1;
  localparam int          DROP_MAX = 65535;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               cfg_enable_i;
  logic [1:0]         cfg_mode_i;
  logic [31:0]        cfg_trig_pc_i;
  logic               cfg_clear_i;
  logic [NRET-1:0]    rvfi_valid;
  logic [NRET*64-1:0] rvfi_order;
  logic [NRET*32-1:0] rvfi_insn;
  logic [NRET*32-1:0] rvfi_pc_rdata;
  logic [NRET*5-1:0]  rvfi_rd_addr;
  logic [NRET*32-1:0] rvfi_rd_wdata;
  logic [NRET-1:0]    rvfi_trap;
  logic [NRET-1:0]    rvfi_intr;
  logic               trace_valid_o;
  logic               trace_ready_i;
  logic [REC_W-1:0]   trace_data_o;
  logic [LVL_W-1:0]   level_o;
  logic [CNT_W-1:0]   drop_cnt_o;
  logic [1:0]         state_o;

  always #5 clk_i = ~clk_i;

  ibex_trace_buffer #(
    .NRET(NRET), .DEPTH(DEPTH), .ORDER_W(ORDER_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cfg_enable_i(cfg_enable_i), .cfg_mode_i(cfg_mode_i),
    .cfg_trig_pc_i(cfg_trig_pc_i), .cfg_clear_i(cfg_clear_i), .rvfi_valid(rvfi_valid),
    .rvfi_order(rvfi_order), .rvfi_insn(rvfi_insn), .rvfi_pc_rdata(rvfi_pc_rdata),
    .rvfi_rd_addr(rvfi_rd_addr), .rvfi_rd_wdata(rvfi_rd_wdata), .rvfi_trap(rvfi_trap),
    .rvfi_intr(rvfi_intr), .trace_valid_o(trace_valid_o), .trace_ready_i(trace_ready_i),
    .trace_data_o(trace_data_o), .level_o(level_o), .drop_cnt_o(drop_cnt_o), .state_o(state_o)
  );

  // Reference model: state, occupancy, drop count, expected records in order.
  int               m_state;
  int               m_level;
  int               m_drop;
  int               m_cycle;
  logic [REC_W-1:0] exp_q[$];
  int               errors;
  int               checks;
  bit               run;
  bit               prev_hold;
  logic [REC_W-1:0] prev_data;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [REC_W-1:0] make_rec(input int l);
    trace_rec_t r;
    r.order    = rvfi_order[l*64 +: TRACE_ORDER_W];
    r.pc       = rvfi_pc_rdata[l*32 +: 32];
    r.insn     = rvfi_insn[l*32 +: 32];
    r.rd_addr  = rvfi_rd_addr[l*5 +: 5];
    r.rd_wdata = rvfi_rd_wdata[l*32 +: 32];
    r.trap     = rvfi_trap[l];
    r.intr     = rvfi_intr[l];
`ifdef IBEX_TRACE_TIMESTAMP_EN
    r.ts       = 32'(m_cycle);
`endif
    return r;
  endfunction

  task automatic set_lane(input int l, input bit v, input logic [31:0] pc);
    rvfi_valid[l]            = v;
    rvfi_pc_rdata[l*32 +: 32] = pc;
    rvfi_order[l*64 +: 64]   = {$urandom, $urandom};
    rvfi_insn[l*32 +: 32]    = $urandom;
    rvfi_rd_addr[l*5 +: 5]   = 5'($urandom);
    rvfi_rd_wdata[l*32 +: 32] = $urandom;
    rvfi_trap[l]             = 1'($urandom);
    rvfi_intr[l]             = 1'($urandom);
  endtask

  // One clock of the model: evaluate the retire rules on the applied inputs, then commit at the edge.
  task automatic step();
    int n_st, n_lvl, n_drop, cand[$];
    bit pop, dropped, hit;
    logic [REC_W-1:0] recs[$];
    int mode;
    mode    = int'(cfg_mode_i);
    n_st    = m_state;
    n_drop  = m_drop;
    dropped = 1'b0;
    hit     = 1'b0;
    if (cfg_clear_i) begin
      n_st = 0; n_lvl = 0; n_drop = 0;
    end else begin
      pop = trace_ready_i && (m_level > 0);
      if (cfg_enable_i) begin
        for (int l = 0; l < NRET; l++) begin
          if (rvfi_valid[l]) begin
            if (m_state == 2) cand.push_back(l);
            else if (m_state == 1) begin
              if (rvfi_pc_rdata[l*32 +: 32] == cfg_trig_pc_i) hit = 1'b1;
              if (hit) cand.push_back(l);
            end
          end
        end
      end
      if (cand.size() > 0) begin
        if (cand.size() > int'(DEPTH) - m_level) begin
          dropped = 1'b1;
          n_drop  = (m_drop + cand.size() > DROP_MAX) ? DROP_MAX : m_drop + cand.size();
        end else begin
          foreach (cand[i]) recs.push_back(make_rec(cand[i]));
        end
      end
      n_lvl = m_level + recs.size() - int'(pop);
      if (!cfg_enable_i) n_st = 0;
      else if (m_state == 0) n_st = (mode == 1) ? 1 : ((mode == 0 || mode == 2) ? 2 : 0);
      else if (m_state == 1) n_st = hit ? 2 : 1;
      else if (m_state == 2) n_st = (dropped && mode == 2) ? 3 : 2;
    end
    @(posedge clk_i);
    if (cfg_clear_i) exp_q.delete();
    foreach (recs[i]) exp_q.push_back(recs[i]);
    m_state = n_st;
    m_level = n_lvl;
    m_drop  = n_drop;
    m_cycle++;
    #1;
  endtask

  task automatic drive(input bit en, input logic [1:0] mode, input bit clr, input bit rdy,
                       input bit v0, input logic [31:0] pc0, input bit v1, input logic [31:0] pc1);
    cfg_enable_i  = en;
    cfg_mode_i    = mode;
    cfg_clear_i   = clr;
    trace_ready_i = rdy;
    set_lane(0, v0, pc0);
    set_lane(1, v1, pc1);
    step();
  endtask

  // Monitor: compares status every cycle and pops the scoreboard on each handshake.
  always @(negedge clk_i) begin
    if (run) begin
      check("valid", 160'(trace_valid_o), 160'(m_level > 0));
      check("level", 160'(level_o), 160'(m_level));
      check("drop_cnt", 160'(drop_cnt_o), 160'(m_drop));
      check("state", 160'(state_o), 160'(m_state));
      if (prev_hold && trace_valid_o) check("hold_stable", 160'(trace_data_o), 160'(prev_data));
      if (trace_valid_o && trace_ready_i) begin
        if (exp_q.size() == 0) check("unexpected_record", 160'(trace_data_o), 160'(0));
        else check("record", 160'(trace_data_o), 160'(exp_q.pop_front()));
      end
      prev_hold = trace_valid_o && !trace_ready_i;
      prev_data = trace_data_o;
    end
  end

  initial begin
    errors = 0; checks = 0; run = 1'b0; prev_hold = 1'b0; prev_data = '0;
    m_state = 0; m_level = 0; m_drop = 0; m_cycle = 0;
    rst_i = 1'b1; cfg_enable_i = 1'b0; cfg_mode_i = 2'd0; cfg_trig_pc_i = 32'h0;
    cfg_clear_i = 1'b0; trace_ready_i = 1'b0;
    rvfi_valid = '0; rvfi_order = '0; rvfi_insn = '0; rvfi_pc_rdata = '0;
    rvfi_rd_addr = '0; rvfi_rd_wdata = '0; rvfi_trap = '0; rvfi_intr = '0;
    repeat (3) @(negedge clk_i);
    check("rst_valid", 160'(trace_valid_o), 160'(0));
    check("rst_level", 160'(level_o), 160'(0));
    check("rst_drop", 160'(drop_cnt_o), 160'(0));
    check("rst_state", 160'(state_o), 160'(0));
    check("rst_data", 160'(trace_data_o), 160'(0));
    rst_i = 1'b0;
    run   = 1'b1;

    // Continuous mode: two lanes captured together, popped in lane order.
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 1, 32'h100, 1, 32'h104);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0);
    repeat (3) drive(1, 2'd0, 0, 1, 0, 0, 0, 0);

    // Trigger mode: only the matching lane and younger are captured.
    drive(0, 2'd1, 1, 0, 0, 0, 0, 0);
    cfg_trig_pc_i = 32'h200;
    drive(1, 2'd1, 0, 0, 0, 0, 0, 0);
    drive(1, 2'd1, 0, 0, 1, 32'h1F8, 0, 0);
    drive(1, 2'd1, 0, 0, 1, 32'h1FC, 1, 32'h200);
    drive(1, 2'd1, 0, 1, 0, 0, 0, 0);
    drive(1, 2'd1, 0, 1, 0, 0, 0, 0);

    // Freeze mode: fill to 15, then a two-lane retire is dropped whole.
    drive(1, 2'd2, 1, 0, 0, 0, 0, 0);
    drive(1, 2'd2, 0, 0, 0, 0, 0, 0);
    repeat (15) drive(1, 2'd2, 0, 0, 1, $urandom, 0, 0);
    drive(1, 2'd2, 0, 0, 1, 32'h300, 1, 32'h304);
    drive(1, 2'd2, 0, 0, 1, 32'h308, 1, 32'h30C);

    // Full with back-pressure, then steady single-lane push with pop.
    drive(0, 2'd0, 0, 0, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 0, 0, 0, 0);
    drive(1, 2'd0, 0, 0, 1, 32'h400, 0, 0);
    repeat (20) drive(1, 2'd0, 0, 0, 1, $urandom, 0, 0);
    repeat (10) drive(1, 2'd0, 0, 1, 1, $urandom, 0, 0);

    // Clear wins over a simultaneous push and pop.
    drive(1, 2'd0, 1, 1, 1, 32'h500, 1, 32'h504);
    drive(1, 2'd0, 0, 1, 0, 0, 0, 0);

    // Randomized traffic across modes, enables, back-pressure and clears.
    for (int i = 0; i < 600; i++) begin
      logic [31:0] pcs [4];
      logic [1:0]  md;
      pcs[0] = 32'h1FC; pcs[1] = 32'h200; pcs[2] = 32'h204; pcs[3] = $urandom;
      if (i % 50 == 0) cfg_trig_pc_i = pcs[$urandom_range(0, 2)];
      md = 2'($urandom_range(0, 2));
      if (i % 40 != 0) md = cfg_mode_i;
      drive($urandom_range(0, 31) != 0, md, $urandom_range(0, 99) == 0,
            $urandom_range(0, 3) != 0,
            1'($urandom), pcs[$urandom_range(0, 3)], 1'($urandom), pcs[$urandom_range(0, 3)]);
    end

    // Drain with a bounded cycle budget.
    for (int i = 0; i < 40 && m_level > 0; i++) drive(0, 2'd0, 0, 1, 0, 0, 0, 0);
    check("drain_level", 160'(m_level), 160'(0));
    check("scoreboard_empty", 160'(exp_q.size()), 160'(0));

    run = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
